mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory stage plus MEM/WB pipeline register of the 5-stage RV32I core. Consumes the EX/MEM register outputs, drives a valid/grant/rvalid data-memory bus, performs byte/halfword store lane steering and load extraction/extension, and registers the writeback-stage signals. Asserts a stall to the hazard unit while a memory access is outstanding.

## Interface
- No parameters; widths fixed (XLEN 32, 5-bit register index).
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- RegWriteM, MemWriteM  in  1  from EX/MEM
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4 (11 treated as 00)
- Funct3M  in  3  load/store size/sign (added to EX/MEM alongside this block)
- ALUResultM, WriteDataM, PCPlus4M  in  32  from EX/MEM
- RdM  in  5  destination register
- DmemReq  out  1  request valid; address/data/strobes held stable until DmemGnt
- DmemWe  out  1  1 store, 0 load
- DmemAddr  out  32  {ALUResultM[31:2], 2'b00}
- DmemWdata  out  32  lane-steered store data
- DmemBe  out  4  byte enables (0000 for loads)
- DmemGnt  in  1  request accepted this cycle
- DmemRvalid  in  1  load data valid
- DmemRdata  in  32  load data word
- StallM  out  1  combinational; 1 = hold IF/ID/EX/EX-MEM this cycle
- AccessFaultM  out  1  combinational; misaligned or illegal Funct3M on a memory op
- RegWriteW  out  1; ResultSrcW  out  2; RdW  out  5
- ALUResultW, ReadDataW, PCPlus4W  out  32  MEM/WB register

## Operation
- Memory op in M: load = ResultSrcM==01; store = MemWriteM. Both set: store wins, no load.
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw. Other Funct3M = fault.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Fault → no request issued, instruction completes immediately, RegWriteW captured as 0, AccessFaultM=1.
- Store steering: sb data byte replicated to all lanes, Be = 0001<<addr[1:0]; sh halfword replicated, Be = 0011<<addr[1:0]; sw Be = 1111.
- Load extraction: select lane by addr[1:0] from DmemRdata; sign-extend for lb/lh, zero-extend for lbu/lhu.
- FSM states: IDLE, REQ (DmemReq held, awaiting grant), RESP (load granted, awaiting rvalid).
  - IDLE: legal memory op → DmemReq=1 same cycle. Gnt=1: store completes; load → RESP. Gnt=0 → REQ.
  - REQ: DmemReq=1. Gnt=1: store → IDLE (complete); load → RESP.
  - RESP: DmemReq=0. Rvalid=1 → IDLE (complete, ReadDataW captured).
- Completion cycle: non-memory op, fault, store grant, or load rvalid. StallM = memory op present && !completion.
- MEM/WB register: on completion capture all M signals (ReadDataW only on load completion, else 0); on stall cycles load a bubble (RegWriteW=0, RdW=0, others 0) so WB never writes twice.
- DmemRvalid outside RESP, DmemGnt while DmemReq=0: ignored.

## Timing
- Reset: state IDLE; RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W = 0; DmemReq=0.
- Reset mid-access drops the request next edge; outstanding rvalid afterwards is ignored.
- Non-memory op / zero-wait store: 0 stall cycles, W valid next edge.
- Load with Gnt same cycle, Rvalid next cycle: 1 stall cycle, W valid edge after Rvalid.
- Earliest rvalid is the cycle after grant; Rvalid in the grant cycle is ignored.
- StallM and DmemReq are combinational from state and M inputs; no path from DmemRdata to StallM.

## Structure
- Shared pipeline_pkg: ResultSrc encodings, load/store Funct3 constants, mem_state_t enum (IDLE/REQ/RESP).
- One sub-module, mem_align: combinational store steering/byte enables, load extract/extend, misalign/fault detect.

## Test plan
- ALU op RdM=5, ALUResultM=0x1234 → no DmemReq, StallM=0; next edge RegWriteW=1, RdW=5, ALUResultW=0x1234.
- sb addr 0x103, WriteDataM=0xAB, Gnt same cycle → DmemBe=1000, DmemWdata=0xABABABAB, DmemAddr=0x100, StallM=0.
- lb addr 0x102, Gnt after 2 cycles, Rvalid 1 cycle later, Rdata=0x00800000 → StallM high 3 cycles, bubbles in W, then ReadDataW=0xFFFFFF80; lbu same → 0x00000080.
- lw addr 0x106 → no request, AccessFaultM=1, RegWriteW=0, StallM=0.
- Reset asserted in RESP → next cycle IDLE, all W outputs 0; late Rvalid ignored, next instruction proceeds normally.
- Back-to-back sw then lh addr 0x202, Rdata=0x8001xxxx → two separate requests, ReadDataW=0xFFFF8001, exactly one W write per instruction.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline: writeback source select, load/store
// size codes and the memory-stage bus handshake states.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational data-memory alignment: store lane steering and byte enables,
// load lane extraction with sign/zero extension, and access fault detection.
module mem_align
    import pipeline_pkg::*;
(
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] load_data,
    output logic            fault
);

    logic                   legal_f3;
    logic                   misaligned;
    logic [XLEN-1:0]        shifted;
    logic signed [7:0]      lane_b;
    logic signed [15:0]     lane_h;

    // Shift the addressed byte down to bit 0; halfword lanes fall out of the same shift.
    assign shifted = load_word >> {addr_lo, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = shifted[15:0];

    always_comb begin
        legal_f3 = 1'b1;
        if (is_store)
            legal_f3 = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else if (is_load)
            legal_f3 = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        fault = (is_load || is_store) && (!legal_f3 || misaligned);
    end

    always_comb begin
        wdata = store_data;
        be    = 4'b0000;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << addr_lo;
                end
                2'b01: begin
                    wdata = {2{store_data[15:0]}};
                    be    = 4'b0011 << addr_lo;
                end
                default: be = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = XLEN'(lane_b);
            F3_H:    load_data = XLEN'(lane_h);
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB register: drives the req/grant/rvalid data bus,
// stalls the front of the pipe while an access is outstanding.
module mem_wb_stage
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [4:0]      RdM,
    output logic            DmemReq,
    output logic            DmemWe,
    output logic [XLEN-1:0] DmemAddr,
    output logic [XLEN-1:0] DmemWdata,
    output logic [3:0]      DmemBe,
    input  logic            DmemGnt,
    input  logic            DmemRvalid,
    input  logic [XLEN-1:0] DmemRdata,
    output logic            StallM,
    output logic            AccessFaultM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W
);

    mem_state_t      state, state_next;
    logic            is_load, is_store, mem_op, fault, legal;
    logic            complete, load_done;
    logic [XLEN-1:0] wdata_al, load_data;
    logic [3:0]      be_al;

    // A store with ResultSrcM==01 is still only a store.
    assign is_store = MemWriteM;
    assign is_load  = (ResultSrcM == RES_LOAD) && !MemWriteM;
    assign mem_op   = is_load || is_store;
    assign legal    = mem_op && !fault;

    mem_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (Funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .load_word  (DmemRdata),
        .wdata      (wdata_al),
        .be         (be_al),
        .load_data  (load_data),
        .fault      (fault)
    );

    assign DmemAddr     = {ALUResultM[31:2], 2'b00};
    assign DmemWe       = is_store;
    assign DmemWdata    = wdata_al;
    assign DmemBe       = is_store ? be_al : 4'b0000;
    assign AccessFaultM = fault;
    assign StallM       = mem_op && !complete;

    always_comb begin
        state_next = state;
        DmemReq    = 1'b0;
        complete   = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE, REQ: begin
                if (!legal) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    DmemReq = 1'b1;
                    if (DmemGnt) begin
                        if (is_store) begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = RESP;
                        end
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            RESP: begin
                if (DmemRvalid) begin
                    complete   = 1'b1;
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // MEM/WB boundary: capture on completion, otherwise insert a bubble.
    always_ff @(posedge clk) begin
        if (reset || !complete) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
            RdW        <= 5'd0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
        end else begin
            RegWriteW  <= RegWriteM && !fault;
            ResultSrcW <= (ResultSrcM == 2'b11) ? RES_ALU : ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_done ? load_data : '0;
            PCPlus4W   <= PCPlus4M;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a behavioural model
// of the memory stage and a bus responder with programmable grant/rvalid delay.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        DmemReq, DmemWe;
    logic [31:0] DmemAddr, DmemWdata;
    logic [3:0]  DmemBe;
    logic        DmemGnt, DmemRvalid;
    logic [31:0] DmemRdata;
    logic        StallM, AccessFaultM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .ResultSrcM   (ResultSrcM),
        .Funct3M      (Funct3M),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .PCPlus4M     (PCPlus4M),
        .RdM          (RdM),
        .DmemReq      (DmemReq),
        .DmemWe       (DmemWe),
        .DmemAddr     (DmemAddr),
        .DmemWdata    (DmemWdata),
        .DmemBe       (DmemBe),
        .DmemGnt      (DmemGnt),
        .DmemRvalid   (DmemRvalid),
        .DmemRdata    (DmemRdata),
        .StallM       (StallM),
        .AccessFaultM (AccessFaultM),
        .RegWriteW    (RegWriteW),
        .ResultSrcW   (ResultSrcW),
        .RdW          (RdW),
        .ALUResultW   (ALUResultW),
        .ReadDataW    (ReadDataW),
        .PCPlus4W     (PCPlus4W)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fault(bit ld, bit st, logic [2:0] f3, logic [1:0] a);
        bit ok;
        if (!ld && !st) return 1'b0;
        ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!ok) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
        int unsigned bytev, halfv;
        bytev = (w >> (8 * a)) & 32'hFF;
        halfv = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (bytev >= 128)   ? (bytev | 32'hFFFFFF00) : bytev;
            3'd1:    return (halfv >= 32768) ? (halfv | 32'hFFFF0000) : halfv;
            3'd4:    return bytev;
            3'd5:    return halfv;
            default: return w;
        endcase
    endfunction

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        Funct3M    = 3'd0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        PCPlus4M   = 32'd0;
        RdM        = 5'd0;
    endtask

    task automatic check_w_zero(input string tag);
        chk({tag, ".RegWriteW"},  32'(RegWriteW),  32'd0);
        chk({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'd0);
        chk({tag, ".RdW"},        32'(RdW),        32'd0);
        chk({tag, ".ALUResultW"}, ALUResultW,      32'd0);
        chk({tag, ".ReadDataW"},  ReadDataW,       32'd0);
        chk({tag, ".PCPlus4W"},   PCPlus4W,        32'd0);
    endtask

    // Issue one instruction in M and play the bus responder until it retires.
    task automatic exec(input string tag, input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] rd, input int gdel,
                        input int rvdel, input logic [31:0] rdata, output int stalls);
        bit          st, ld, flt, lg, granted, done, cmp, expreq;
        int          cyc, since;
        logic [31:0] expw;
        logic [3:0]  expbe;
        logic [7:0]  b8;
        logic [15:0] h16;
        st  = mw;
        ld  = (rs == 2'd1) && !mw;
        flt = model_fault(ld, st, f3, alu[1:0]);
        lg  = (ld || st) && !flt;
        b8  = wd[7:0];
        h16 = wd[15:0];
        case (f3)
            3'd0: begin expw = {b8, b8, b8, b8}; expbe = 4'(1 << alu[1:0]); end
            3'd1: begin expw = {h16, h16};      expbe = 4'(3 << alu[1:0]); end
            default: begin expw = wd;           expbe = 4'hF; end
        endcase
        granted = 0; done = 0; cyc = 0; since = 0; stalls = 0;
        while (!done) begin
            if (cyc >= 60) begin
                checks++;
                errors++;
                $error("FAIL %s.timeout observed=no_completion expected=completion", tag);
                break;
            end
            @(negedge clk);
            RegWriteM  = rw;
            MemWriteM  = mw;
            ResultSrcM = rs;
            Funct3M    = f3;
            ALUResultM = alu;
            WriteDataM = wd;
            PCPlus4M   = pc4;
            RdM        = rd;
            DmemRdata  = $urandom;
            if (lg && !granted) begin
                DmemGnt    = (cyc == gdel);
                DmemRvalid = 1'($urandom_range(0, 1));
            end else if (lg && granted) begin
                DmemGnt    = 1'($urandom_range(0, 1));
                DmemRvalid = (since == rvdel);
                if (DmemRvalid) DmemRdata = rdata;
            end else begin
                DmemGnt    = 1'($urandom_range(0, 1));
                DmemRvalid = 1'($urandom_range(0, 1));
            end
            #1;
            expreq = lg && !granted;
            cmp    = !lg || (!granted && DmemGnt && st) || (granted && DmemRvalid);
            chk({tag, ".DmemReq"},      32'(DmemReq),      32'(expreq));
            chk({tag, ".StallM"},       32'(StallM),       32'(!cmp));
            chk({tag, ".AccessFaultM"}, 32'(AccessFaultM), 32'(flt));
            if (expreq) begin
                chk({tag, ".DmemAddr"}, DmemAddr,     alu & 32'hFFFF_FFFC);
                chk({tag, ".DmemWe"},   32'(DmemWe),  32'(st));
                chk({tag, ".DmemBe"},   32'(DmemBe),  st ? 32'(expbe) : 32'd0);
                if (st) chk({tag, ".DmemWdata"}, DmemWdata, expw);
            end
            if (!cmp) stalls++;
            @(posedge clk);
            #1;
            if (cmp) begin
                chk({tag, ".RegWriteW"},  32'(RegWriteW),  32'(rw && !flt));
                chk({tag, ".ResultSrcW"}, 32'(ResultSrcW), (rs == 2'd3) ? 32'd0 : 32'(rs));
                chk({tag, ".RdW"},        32'(RdW),        32'(rd));
                chk({tag, ".ALUResultW"}, ALUResultW,      alu);
                chk({tag, ".ReadDataW"},  ReadDataW,       lg && ld ? model_load(f3, alu[1:0], rdata) : 32'd0);
                chk({tag, ".PCPlus4W"},   PCPlus4W,        pc4);
                done = 1;
            end else begin
                check_w_zero({tag, ".bubble"});
            end
            if (lg && !granted && DmemGnt) granted = 1;
            else if (granted) since++;
            cyc++;
        end
    endtask

    initial begin
        int          s;
        int          kind;
        logic        rw, mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [2:0]  legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset      = 1'b1;
        DmemGnt    = 1'b0;
        DmemRvalid = 1'b0;
        DmemRdata  = 32'd0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check_w_zero("reset");
        chk("reset.DmemReq", 32'(DmemReq), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        exec("alu", 1, 0, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h8, 5'd5, 0, 0, 32'h0, s);
        chk("alu.stalls", 32'(s), 32'd0);
        chk("alu.RegWriteW", 32'(RegWriteW), 32'd1);

        exec("sb", 0, 1, 2'd0, 3'd0, 32'h103, 32'hAB, 32'h10, 5'd0, 0, 0, 32'h0, s);
        chk("sb.stalls", 32'(s), 32'd0);

        exec("lb", 1, 0, 2'd1, 3'd0, 32'h102, 32'h0, 32'h14, 5'd7, 2, 0, 32'h0080_0000, s);
        chk("lb.stalls", 32'(s), 32'd3);
        chk("lb.value", ReadDataW, 32'hFFFF_FF80);

        exec("lbu", 1, 0, 2'd1, 3'd4, 32'h102, 32'h0, 32'h18, 5'd8, 2, 0, 32'h0080_0000, s);
        chk("lbu.stalls", 32'(s), 32'd3);
        chk("lbu.value", ReadDataW, 32'h0000_0080);

        exec("lw_mis", 1, 0, 2'd1, 3'd2, 32'h106, 32'h0, 32'h1C, 5'd9, 0, 0, 32'h0, s);
        chk("lw_mis.stalls", 32'(s), 32'd0);

        // Reset while a load waits for its response.
        @(negedge clk);
        RegWriteM = 1; MemWriteM = 0; ResultSrcM = 2'd1; Funct3M = 3'd2;
        ALUResultM = 32'h200; RdM = 5'd3; PCPlus4M = 32'h20;
        DmemGnt = 1; DmemRvalid = 0;
        @(negedge clk);
        DmemGnt = 0;
        #1;
        chk("rst_resp.DmemReq", 32'(DmemReq), 32'd0);
        chk("rst_resp.StallM",  32'(StallM),  32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_w_zero("rst_resp");
        @(negedge clk);
        reset = 1'b0;
        drive_nop();
        DmemRvalid = 1'b1;
        DmemRdata  = 32'hDEAD_BEEF;
        #1;
        chk("rst_late.DmemReq", 32'(DmemReq), 32'd0);
        chk("rst_late.StallM",  32'(StallM),  32'd0);
        @(posedge clk);
        #1;
        chk("rst_late.ReadDataW", ReadDataW, 32'd0);
        exec("after_rst", 1, 0, 2'd0, 3'd0, 32'h55, 32'h0, 32'h24, 5'd4, 0, 0, 32'h0, s);

        exec("sw", 0, 1, 2'd0, 3'd2, 32'h200, 32'hCAFE_F00D, 32'h28, 5'd0, 1, 0, 32'h0, s);
        chk("sw.stalls", 32'(s), 32'd1);
        exec("lh", 1, 0, 2'd1, 3'd1, 32'h202, 32'h0, 32'h2C, 5'd10, 0, 1, 32'h8001_1234, s);
        chk("lh.stalls", 32'(s), 32'd2);
        chk("lh.value", ReadDataW, 32'hFFFF_8001);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            rw = 1; mw = 0; rs = 2'd0;
            f3 = 3'($urandom_range(0, 7));
            case (kind)
                0: rs = $urandom_range(0, 1) ? 2'd3 : 2'd0;
                1: begin
                    rs = 2'd1;
                    if ($urandom_range(0, 3) != 0) f3 = legal_ld[$urandom_range(0, 4)];
                end
                2: begin
                    rw = 0; mw = 1; rs = 2'($urandom_range(0, 2));
                    if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
                end
                default: rs = 2'd2;
            endcase
            exec($sformatf("rnd%0d", i), rw, mw, rs, f3, $urandom, $urandom, $urandom,
                 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
